seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001: Parameter WIDTH, default 16, datapath width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002: Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL not be overridden independently of WIDTH.
REQ-003: clk  input  1  single clock, all state updates on the rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  operand/opcode presented.
REQ-006: in_ready  output  1  block accepts a new operation.
REQ-007: a  input  WIDTH  operand A.
REQ-008: b  input  WIDTH  operand B; B[SHW-1:0] is the shift/rotate amount.
REQ-009: opcode  input  3  000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
REQ-010: out_valid  output  1  result and flags valid.
REQ-011: out_ready  input  1  consumer accepts the result.
REQ-012: result  output  WIDTH  registered result.
REQ-013: flags  output  3  registered {N,V,Z}.
REQ-014: busy  output  1  high whenever the state is not IDLE.

Function
REQ-015: FSM states SHALL be IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016: On a rising edge with in_valid & in_ready, the block SHALL latch a, b and opcode, load counter cnt with B[SHW-1:0] and enter EXEC.
REQ-017: In EXEC, non-shift ops SHALL load result at the next edge and enter DONE, so out_valid rises one cycle after acceptance.
REQ-018: In EXEC, shift ops SHALL shift a working register by one bit per edge while cnt != 0, decrementing cnt; at the edge with cnt == 0 they SHALL load result and enter DONE, so out_valid rises shamt+1 cycles after acceptance.
REQ-019: ADD/SUB SHALL be signed WIDTH-bit arithmetic saturating to 2^(WIDTH-1)-1 or -2^(WIDTH-1); V SHALL be set when the unsaturated result overflows.
REQ-020: XOR SHALL compute A ^ B.
REQ-021: RED SHALL sum all WIDTH/8 signed bytes of A and all WIDTH/8 signed bytes of B, then sign-extend the sum to WIDTH.
REQ-022: PADDSB SHALL add each 4-bit lane as a signed value, saturating to +7 or -8, independently per lane.
REQ-023: SLL SHALL fill with 0, SRA SHALL fill with A[WIDTH-1], and ROR SHALL rotate right; shamt 0 SHALL return A unchanged.
REQ-024: Flags SHALL update at the edge entering DONE: Z = (result == 0) for every op; N = result[WIDTH-1] and V for ADD/SUB only; N and V SHALL hold their prior values for all other ops.
REQ-025: In DONE, out_valid SHALL be 1 and result/flags SHALL be stable until an edge with out_ready = 1, at which the FSM SHALL return to IDLE.
REQ-026: Back-to-back operation: in_valid asserted during DONE SHALL be ignored; the earliest next acceptance is the cycle after the DONE handshake.
REQ-027: Inputs a, b and opcode SHALL be don't-care outside the accept edge; changing them mid-operation SHALL NOT affect the result.
REQ-028: X-propagation: flags SHALL never be driven from unlatched inputs.

Reset
REQ-029: rst_n low SHALL immediately force state IDLE, cnt 0, result 0, flags 000, out_valid 0, busy 0 and in_ready 1, including mid-EXEC or mid-DONE.
REQ-030: After rst_n deasserts, the first acceptance SHALL be possible at the next rising edge.

Verification
REQ-031: ADD a=0x7FFF b=0x0001, out_ready=1 -> result 0x7FFF, flags {0,1,0}, out_valid 1 cycle after accept.
REQ-032: SUB 0x0005-0x0005 -> 0x0000, flags {0,0,1}; then RED a=0x0102 b=0x0304 -> 0x000A, Z=0, N/V unchanged.
REQ-033: SRA a=0x8000 b=0x0004 -> 0xF800, out_valid exactly 5 cycles after accept; ROR a=0x0001 b=0x0001 -> 0x8000 after 2 cycles.
REQ-034: PADDSB a=0x7777 b=0x1111 -> 0x7777; a=0x8888 b=0xFFFF -> 0x8888.
REQ-035: Hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> result, flags and out_valid held, in_ready 0, no new op accepted.
REQ-036: Assert rst_n=0 during SLL shamt=15 -> outputs reach reset values without a clock edge; after release, in_ready=1 and a new ADD completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle saturating ALU with a valid/ready handshake.
// The operation is accepted in IDLE, evaluated in EXEC and presented in DONE.
// Non-shift ops spend one cycle in EXEC. Shift ops spend shamt+1 cycles there,
// moving one bit per cycle.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready operation handshake (in_ready only in IDLE)
//   a, b, opcode      operands and opcode, latched on the accept edge
//                     (b[SHW-1:0] is the shift/rotate amount)
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   result, flags     registered result and {N,V,Z}
//   busy              state is not IDLE
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
  logic [2:0]       op_q, op_d, flags_q, flags_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             is_shift;
  logic             arith_ovf;
  logic [WIDTH:0]   arith_ext;
  logic [WIDTH-1:0] arith_res, red_sum, padd_res, alu_res;
  logic [4:0]       lane_sum;

  // Handshake and status outputs decode directly from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flags     = flags_q;

  // Combinational datapath for the single-cycle ops, fed only from latched operands.
  always_comb begin
    is_shift = 1'b0;
    // One extra sign bit: overflow shows up as a disagreement between the top two bits.
    if (op_q == OP_SUB) begin
      arith_ext = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    end else begin
      arith_ext = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    end
    arith_ovf = arith_ext[WIDTH] ^ arith_ext[WIDTH-1];
    if (arith_ovf) begin
      arith_res = arith_ext[WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      arith_res = arith_ext[WIDTH-1:0];
    end

    // The byte sum always fits in WIDTH bits, so a WIDTH-bit accumulator is exact.
    red_sum = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH/8; i++) begin
      red_sum = red_sum + {{(WIDTH-8){a_q[8*i+7]}}, a_q[8*i +: 8]}
                        + {{(WIDTH-8){b_q[8*i+7]}}, b_q[8*i +: 8]};
    end

    padd_res = {WIDTH{1'b0}};
    lane_sum = 5'b00000;
    for (int i = 0; i < WIDTH/4; i++) begin
      lane_sum = {a_q[4*i+3], a_q[4*i +: 4]} + {b_q[4*i+3], b_q[4*i +: 4]};
      if (lane_sum[4] != lane_sum[3]) begin
        padd_res[4*i +: 4] = lane_sum[4] ? 4'b1000 : 4'b0111;
      end else begin
        padd_res[4*i +: 4] = lane_sum[3:0];
      end
    end

    case (op_q)
      OP_ADD, OP_SUB: alu_res = arith_res;
      OP_XOR:         alu_res = a_q ^ b_q;
      OP_RED:         alu_res = red_sum;
      OP_PADDSB:      alu_res = padd_res;
      OP_SLL, OP_SRA, OP_ROR: begin
        alu_res  = work_q;
        is_shift = 1'b1;
      end
      default:        alu_res = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic: handshake sequencing, bit-serial shifting and result/flag update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = opcode;
          cnt_d   = b[SHW-1:0];
          work_d  = a;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (is_shift && (cnt_q != CNT_ZERO)) begin
          cnt_d = cnt_q - CNT_ONE;
          case (op_q)
            OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_ROR:  work_d = {work_q[0], work_q[WIDTH-1:1]};
            default: work_d = work_q;
          endcase
        end else begin
          result_d   = alu_res;
          flags_d[0] = (alu_res == {WIDTH{1'b0}});
          // N and V describe signed arithmetic only; other ops leave them alone.
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            flags_d[2] = alu_res[WIDTH-1];
            flags_d[1] = arith_ovf;
          end else begin
            flags_d[2] = flags_q[2];
            flags_d[1] = flags_q[1];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 3'b000;
      cnt_q    <= {SHW{1'b0}};
      work_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule
